tty_write_arbiter: RTL and testbench

TTY_WRITE_ARBITER -- requirements
Module: tty_write_arbiter

---
 rtl/tty_write_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_tty_write_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tty_write_arbiter.sv
// TTY write arbiter: keyboard receive FIFO plus single text-memory writer.
// Optional keyboard echo path enabled by defining TTY_ECHO_EN.
module tty_write_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic       clk_50mhz,
  input  logic       rst_n,
  input  logic       kb_valid,
  input  logic [7:0] kb_ascii,
  input  logic       cpu_write,
  input  logic [7:0] cpu_wdata,
  input  logic       cpu_read,
  output logic [7:0] cpu_rdata,
  output logic       cpu_busy,
  output logic       kb_overrun,
  input  logic       vga_busy,
  output logic       vm_write,
  output logic [7:0] vm_data
);

  localparam int AW = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      STARVE_LIMIT < 0) begin : g_bad_param
    $error("tty_write_arbiter: bad parameters");
  end

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t state;
  state_t state_n;

  logic          grant_cpu;
  logic          grant_echo;
  logic          echo_req;
  logic          echo_wins;
  logic [7:0]    echo_data;
  logic          req;

  // ---------------- keyboard FIFO ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          empty;
  logic          full;
  logic          do_pop;
  logic          do_push;
  logic          ovr_set;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

  // a pop in the same cycle makes room for a push into a full FIFO
  assign do_pop  = cpu_read && !empty;
  assign do_push = kb_valid && (!full || do_pop);
  assign ovr_set = kb_valid && full && !cpu_read;

  assign cpu_rdata = empty ? 8'hFF : mem[rptr[AW-1:0]];

  // storage array, written on every accepted keyboard character
  always_ff @(posedge clk_50mhz) begin
    if (do_push)
      mem[wptr[AW-1:0]] <= kb_ascii;
  end

  // read/write pointers with wrap bit for full/empty detection
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push)
        wptr <= wptr + 1'b1;
      if (do_pop)
        rptr <= rptr + 1'b1;
    end
  end

  // sticky overrun; a same-cycle loss beats the clearing read
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n)
      kb_overrun <= 1'b0;
    else if (ovr_set)
      kb_overrun <= 1'b1;
    else if (cpu_read)
      kb_overrun <= 1'b0;
  end

  // ---------------- CPU hold register ----------------
  logic [7:0]    cpu_hold;
  logic          cpu_hv;
  logic          cpu_take;

  assign cpu_take = cpu_write && (!cpu_hv || grant_cpu);
  assign cpu_busy = cpu_hv;

  // capture a CPU character when the slot is free or freed this cycle
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      cpu_hv   <= 1'b0;
      cpu_hold <= 8'h00;
    end else if (cpu_take) begin
      cpu_hv   <= 1'b1;
      cpu_hold <= cpu_wdata;
    end else if (grant_cpu) begin
      cpu_hv   <= 1'b0;
    end
  end

`ifdef TTY_ECHO_EN
  // ---------------- keyboard echo ----------------
  localparam int SW = $clog2(STARVE_LIMIT + 2);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [7:0]    echo_hold;
  logic          echo_v;
  logic          echo_take;
  logic [SW-1:0] starve;

  assign echo_take = kb_valid && (!echo_v || grant_echo);

  // one-entry echo slot; a busy slot drops the new character
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      echo_v    <= 1'b0;
      echo_hold <= 8'h00;
    end else if (echo_take) begin
      echo_v    <= 1'b1;
      echo_hold <= kb_ascii;
    end else if (grant_echo) begin
      echo_v    <= 1'b0;
    end
  end

  // counts CPU wins while an echo is waiting
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n)
      starve <= '0;
    else if (!echo_v || grant_echo)
      starve <= '0;
    else if (grant_cpu)
      starve <= starve + 1'b1;
  end

  assign echo_req  = echo_v;
  assign echo_data = echo_hold;
  assign echo_wins = echo_v &&
                     (!cpu_hv || starve == LIMIT);
`else
  assign echo_req  = 1'b0;
  assign echo_data = 8'h00;
  assign echo_wins = 1'b0;
`endif

  assign req = cpu_hv || echo_req;

  // ---------------- write FSM ----------------
  // state register
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_n;
  end

  // next state and grant selection
  always_comb begin
    state_n    = state;
    grant_cpu  = 1'b0;
    grant_echo = 1'b0;
    unique case (state)
      IDLE: begin
        if (!vga_busy && req) begin
          state_n = ISSUE;
          if (echo_wins)
            grant_echo = 1'b1;
          else
            grant_cpu  = 1'b1;
        end
      end
      ISSUE: state_n = WAIT;
      WAIT: begin
        if (!vga_busy)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign vm_write = (state == ISSUE);

  // load the winner's character; held until the next grant
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n)
      vm_data <= 8'h00;
    else if (grant_cpu)
      vm_data <= cpu_hold;
    else if (grant_echo)
      vm_data <= echo_data;
  end

endmodule

// File: tb/tb_tty_write_arbiter.sv
// Bench for tty_write_arbiter: scoreboard on vm_write, queue model of
// the keyboard FIFO, directed latency/reset cases, random traffic.
module tb_tty_write_arbiter;

  localparam int D = 4;

  logic       clk_50mhz = 1'b0;
  logic       rst_n = 1'b1;
  logic       kb_valid = 1'b0;
  logic [7:0] kb_ascii = 8'h00;
  logic       cpu_write = 1'b0;
  logic [7:0] cpu_wdata = 8'h00;
  logic       cpu_read = 1'b0;
  logic [7:0] cpu_rdata;
  logic       cpu_busy;
  logic       kb_overrun;
  logic       vga_busy = 1'b0;
  logic       vm_write;
  logic [7:0] vm_data;

  tty_write_arbiter #(.FIFO_DEPTH(D), .STARVE_LIMIT(3)) dut (
    .clk_50mhz (clk_50mhz),
    .rst_n     (rst_n),
    .kb_valid  (kb_valid),
    .kb_ascii  (kb_ascii),
    .cpu_write (cpu_write),
    .cpu_wdata (cpu_wdata),
    .cpu_read  (cpu_read),
    .cpu_rdata (cpu_rdata),
    .cpu_busy  (cpu_busy),
    .kb_overrun(kb_overrun),
    .vga_busy  (vga_busy),
    .vm_write  (vm_write),
    .vm_data   (vm_data)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  bit         sb_on = 1'b0;
  logic [7:0] held;
  bit         chk_hold = 1'b0;

  logic [7:0] fq[$];
  bit         m_ovr = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", nm, act, req);
    end
  endtask

  // scoreboard monitor: every vm_write must match the next expected char
  always @(negedge clk_50mhz) begin
    if (rst_n && sb_on) begin
      if (vm_write) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL vm_write_unexpected got=%0h required=none",
                   vm_data);
        end else begin
          chk("vm_data", vm_data, exp_q.pop_front());
        end
        held = vm_data;
        chk_hold = 1'b1;
      end else if (chk_hold) begin
        chk_hold = 1'b0;
        chk("vm_data_stable", vm_data, held);
      end
    end else begin
      chk_hold = 1'b0;
    end
  end

  task automatic do_reset();
    @(negedge clk_50mhz);
    kb_valid = 0; cpu_write = 0; cpu_read = 0; vga_busy = 0;
    rst_n = 0;
    repeat (2) @(negedge clk_50mhz);
    rst_n = 1;
    exp_q.delete();
    fq.delete();
    m_ovr = 0;
  endtask

  // one FIFO cycle: drive, advance model, compare
  task automatic fifo_cycle(input bit kv, input logic [7:0] ka,
                            input bit rd);
    bit pop, push, fl;
    kb_valid = kv; kb_ascii = ka; cpu_read = rd;
    fl   = (fq.size() == D);
    pop  = rd && fq.size() > 0;
    push = kv && (!fl || pop);
    if (pop) void'(fq.pop_front());
    if (push) fq.push_back(ka);
    if (kv && fl && !rd) m_ovr = 1;
    else if (rd) m_ovr = 0;
    @(negedge clk_50mhz);
    kb_valid = 0; cpu_read = 0;
    chk("cpu_rdata", cpu_rdata, fq.size() > 0 ? fq[0] : 8'hFF);
    chk("kb_overrun", kb_overrun, m_ovr);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [7:0] got [4];
    logic [7:0] d;

    // reset values, checked while reset is held
    #5 rst_n = 0;
    #1;
    chk("rst_vm_write", vm_write, 0);
    chk("rst_vm_data", vm_data, 0);
    chk("rst_cpu_busy", cpu_busy, 0);
    chk("rst_overrun", kb_overrun, 0);
    chk("rst_rdata", cpu_rdata, 8'hFF);
    do_reset();
    sb_on = 1;

    // basic CPU write latency
    cpu_write = 1; cpu_wdata = 8'h41; exp_q.push_back(8'h41);
    @(negedge clk_50mhz);
    cpu_write = 0;
    chk("lat_busy1", cpu_busy, 1);
    chk("lat_vmw1", vm_write, 0);
    @(negedge clk_50mhz);
    chk("lat_vmw2", vm_write, 1);
    chk("lat_data", vm_data, 8'h41);
    chk("lat_busy2", cpu_busy, 0);
    repeat (3) @(negedge clk_50mhz);

    // long vga_busy, write ignored while busy
    cpu_write = 1; cpu_wdata = 8'h50; exp_q.push_back(8'h50);
    @(negedge clk_50mhz);
    cpu_write = 0;
    @(negedge clk_50mhz);
    chk("issue_50", vm_write, 1);
    vga_busy = 1;
    cpu_write = 1; cpu_wdata = 8'h51; exp_q.push_back(8'h51);
    @(negedge clk_50mhz);
    cpu_wdata = 8'h52;
    @(negedge clk_50mhz);
    cpu_write = 0;
    chk("busy_held", cpu_busy, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_50mhz);
      chk("wait_no_vmw", vm_write, 0);
    end
    vga_busy = 0;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk_50mhz);
      if (vm_write) begin
        n = i;
        break;
      end
    end
    chk("release_lat", n, 2);
    repeat (10) @(negedge clk_50mhz);
    chk("sb_drain1", exp_q.size(), 0);

    // FIFO overrun with no reads
    do_reset();
`ifdef TTY_ECHO_EN
    sb_on = 0;
`endif
    for (int i = 0; i < 5; i++)
      fifo_cycle(1, 8'h30 + 8'(i), 0);
    chk("ovr_set", kb_overrun, 1);
    chk("ovr_head", cpu_rdata, 8'h30);
    for (int i = 0; i < 5; i++)
      fifo_cycle(0, 8'h00, 1);
    chk("drained_ff", cpu_rdata, 8'hFF);

    // push into a full FIFO with a same-cycle pop
    do_reset();
    for (int i = 0; i < 4; i++)
      fifo_cycle(1, 8'h30 + 8'(i), 0);
    fifo_cycle(1, 8'h35, 1);
    chk("full_rw_ovr", kb_overrun, 0);
    chk("full_rw_head", cpu_rdata, 8'h31);
    for (int i = 0; i < 4; i++)
      fifo_cycle(0, 8'h00, 1);

    // random FIFO traffic
    for (int i = 0; i < 300; i++)
      fifo_cycle(1'($urandom_range(0, 1)), 8'($urandom),
                 $urandom_range(0, 9) < 4);

    // random CPU writes against a random sink
    do_reset();
    sb_on = 1;
    for (int k = 0; k < 30; k++) begin
      d = 8'($urandom);
      cpu_write = 1; cpu_wdata = d; exp_q.push_back(d);
      vga_busy = ($urandom_range(0, 3) == 0);
      @(negedge clk_50mhz);
      cpu_write = 0;
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
        vga_busy = ($urandom_range(0, 3) == 0);
        @(negedge clk_50mhz);
        n++;
      end
      chk("rand_drain", exp_q.size(), 0);
    end
    vga_busy = 0;
    repeat (4) @(negedge clk_50mhz);

`ifdef TTY_ECHO_EN
    // echo starvation limit
    do_reset();
    sb_on = 0;
    kb_valid = 1; kb_ascii = 8'h61;
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      cpu_write = 1; cpu_wdata = 8'hC0 + 8'(i);
      @(negedge clk_50mhz);
      kb_valid = 0;
      if (vm_write) begin
        got[n] = vm_data;
        n++;
      end
    end
    cpu_write = 0;
    chk("echo_count", n, 4);
    chk("echo_cpu0", got[0][7:4], 4'hC);
    chk("echo_cpu1", got[1][7:4], 4'hC);
    chk("echo_cpu2", got[2][7:4], 4'hC);
    chk("echo_char", got[3], 8'h61);
    repeat (6) @(negedge clk_50mhz);
`else
    got[0] = 8'h00;
    chk("got_unused", got[0], 8'h00);
`endif

    // reset during WAIT with more work pending
    do_reset();
    sb_on = 1;
    cpu_write = 1; cpu_wdata = 8'h71; exp_q.push_back(8'h71);
    @(negedge clk_50mhz);
    cpu_write = 0;
    @(negedge clk_50mhz);
    chk("rw_issue", vm_write, 1);
    vga_busy = 1;
    cpu_write = 1; cpu_wdata = 8'h72;
    kb_valid = 1; kb_ascii = 8'h63;
    @(negedge clk_50mhz);
    cpu_write = 0; kb_valid = 0;
    @(negedge clk_50mhz);
    #5 rst_n = 0;
    #1;
    chk("rw_vm_write", vm_write, 0);
    chk("rw_vm_data", vm_data, 0);
    chk("rw_cpu_busy", cpu_busy, 0);
    chk("rw_overrun", kb_overrun, 0);
    chk("rw_rdata", cpu_rdata, 8'hFF);
    @(negedge clk_50mhz);
    rst_n = 1;
    vga_busy = 0;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_50mhz);
      if (vm_write) n++;
    end
    chk("rw_no_write", n, 0);
    chk("sb_final", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
